// File: rtl/branch_resolver.sv
// branch_resolver: resolve-side branch predictor.
// A table of 2-bit saturating counters supplies the fetch-side direction bit.
// Every accepted prediction is queued in order. When execute resolves the
// oldest branch, the queued predicted next-PC is compared with the actual
// next-PC. A mismatch redirects fetch for one cycle and squashes everything
// younger. Every resolve also trains the counter of the resolved branch.
module branch_resolver #(
    parameter int IDX_WIDTH = 10,
    parameter int DEPTH     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pred_valid_i,
    input  logic [31:0] pred_pc_i,
    input  logic [31:0] pred_target_i,
    output logic        pred_taken_o,
    output logic        pred_ready_o,
    input  logic        res_valid_i,
    input  logic        res_taken_i,
    input  logic [31:0] res_pc_next_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    output logic        underflow_o
);

    localparam int PHT_N = 2 ** IDX_WIDTH;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    // Pattern history table.
    logic [1:0]           r_pht [PHT_N];

    // In-flight queue. Only the table index of the branch PC is kept,
    // because training is the only consumer of that PC.
    logic [IDX_WIDTH-1:0] r_fifo_idx  [DEPTH];
    logic [31:0]          r_fifo_next [DEPTH];
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;

    logic [IDX_WIDTH-1:0] w_lkp_idx;
    logic [31:0]          w_pred_next;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_mis;
    logic [IDX_WIDTH-1:0] w_head_idx;
    logic [31:0]          w_head_next;
    logic [1:0]           w_cnt_old;
    logic [1:0]           w_cnt_new;

    // Lookup is a plain read. A counter trained in the same cycle is seen with its old value.
    assign w_lkp_idx    = pred_pc_i[IDX_WIDTH+1:2];
    assign pred_taken_o = r_pht[w_lkp_idx][1];
    assign w_pred_next  = pred_taken_o ? pred_target_i : pred_pc_i + 32'd4;

    assign w_full       = (r_count == CW'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign pred_ready_o = !w_full;

    assign w_push       = pred_valid_i && !w_full;
    assign w_pop        = res_valid_i && !w_empty;

    assign w_head_idx   = r_fifo_idx[r_rd_ptr];
    assign w_head_next  = r_fifo_next[r_rd_ptr];
    assign w_mis        = w_pop && (w_head_next != res_pc_next_i);

    // Saturating step of the head branch's counter toward the resolved direction.
    always_comb begin
        w_cnt_old = r_pht[w_head_idx];
        w_cnt_new = w_cnt_old;
        if (res_taken_i) begin
            if (w_cnt_old != 2'b11) w_cnt_new = w_cnt_old + 2'b01;
        end else begin
            if (w_cnt_old != 2'b00) w_cnt_new = w_cnt_old - 2'b01;
        end
    end

    // Train the counter on every pop. Reset sets all counters to weakly not-taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PHT_N; i++) r_pht[i] <= 2'b01;
        end else if (w_pop) begin
            r_pht[w_head_idx] <= w_cnt_new;
        end
    end

    // Queue payload. Validity is carried by the count alone, so the payload needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_push && !w_mis) begin
            r_fifo_idx[r_wr_ptr]  <= w_lkp_idx;
            r_fifo_next[r_wr_ptr] <= w_pred_next;
        end
    end

    // Queue pointers and occupancy. A mispredict squashes all entries, including a same-cycle push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_mis) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Registered redirect and underflow pulses. The redirect PC holds until the next mispredict.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mispredict_o  <= 1'b0;
            redirect_pc_o <= 32'd0;
            underflow_o   <= 1'b0;
        end else begin
            mispredict_o <= w_mis;
            underflow_o  <= res_valid_i && w_empty;
            if (w_mis) redirect_pc_o <= res_pc_next_i;
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a behavioural model predicts outputs per cycle.
module tb_branch_resolver;

    localparam int IW    = 10;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pred_valid_i;
    logic [31:0] pred_pc_i;
    logic [31:0] pred_target_i;
    logic        pred_taken_o;
    logic        pred_ready_o;
    logic        res_valid_i;
    logic        res_taken_i;
    logic [31:0] res_pc_next_i;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic        underflow_o;

    branch_resolver #(.IDX_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i), .pred_target_i(pred_target_i),
        .pred_taken_o(pred_taken_o), .pred_ready_o(pred_ready_o),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_pc_next_i(res_pc_next_i),
        .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o), .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] pc; logic [31:0] nxt; } ent_t;
    typedef struct { logic mis; logic [31:0] rpc; logic uf; } exp_t;

    logic [1:0]  m_pht [1 << IW];
    ent_t        m_q[$];
    exp_t        exp_q[$];
    logic [31:0] m_redir;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < (1 << IW); i++) m_pht[i] = 2'b01;
        m_q.delete();
        exp_q.delete();
        m_redir = 32'd0;
    endtask

    task automatic idle();
        pred_valid_i = 0; pred_pc_i = 0; pred_target_i = 0;
        res_valid_i = 0; res_taken_i = 0; res_pc_next_i = 0;
    endtask

    // One clock: drive, check combinational outputs, update model, check registered outputs.
    task automatic cyc(input logic pv, input logic [31:0] ppc, input logic [31:0] ptgt,
                       input logic rv, input logic rt, input logic [31:0] rnx);
        logic tk, rdy, push, pop, mis;
        logic [IW-1:0] ti;
        ent_t h;
        exp_t e;
        pred_valid_i = pv; pred_pc_i = ppc; pred_target_i = ptgt;
        res_valid_i = rv; res_taken_i = rt; res_pc_next_i = rnx;
        #1;
        tk  = m_pht[ppc[IW+1:2]][1];
        rdy = m_q.size() < DEPTH;
        chk("pred_taken", 32'(pred_taken_o), 32'(tk));
        chk("pred_ready", 32'(pred_ready_o), 32'(rdy));
        push = pv && rdy;
        pop  = rv && (m_q.size() != 0);
        mis  = 1'b0;
        e.uf = rv && (m_q.size() == 0);
        if (pop) begin
            h  = m_q[0];
            mis = (h.nxt != rnx);
            ti = h.pc[IW+1:2];
            if (rt && m_pht[ti] != 2'b11) m_pht[ti] = m_pht[ti] + 2'b01;
            else if (!rt && m_pht[ti] != 2'b00) m_pht[ti] = m_pht[ti] - 2'b01;
        end
        if (mis) begin
            m_redir = rnx;
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back('{ppc, tk ? ptgt : ppc + 32'd4});
        end
        e.mis = mis;
        e.rpc = m_redir;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        chk("mispredict", 32'(mispredict_o), 32'(e.mis));
        chk("redirect_pc", redirect_pc_o, e.rpc);
        chk("underflow", 32'(underflow_o), 32'(e.uf));
        idle();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        m_reset();
        #3;
        chk("rst_mis", 32'(mispredict_o), 32'd0);
        chk("rst_rpc", redirect_pc_o, 32'd0);
        chk("rst_uf", 32'(underflow_o), 32'd0);
        chk("rst_ready", 32'(pred_ready_o), 32'd1);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] pc, nx;
        idle();
        rst_i = 1'b1;
        m_reset();
        #2;
        do_reset();

        // 1: weakly not-taken predicts pc+4; correct resolve trains 01 -> 00
        cyc(1, 32'h100, 32'h200, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 32'h104);
        cyc(0, 32'h100, 0, 0, 0, 0);

        // 2: from reset, taken resolve mispredicts, counter 01 -> 10
        do_reset();
        cyc(1, 32'h100, 32'h200, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h200);
        cyc(0, 32'h100, 32'h200, 0, 0, 0);

        // 3: fill, dropped 5th push, drain in order
        for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 32'(i * 4), 32'h900, 0, 0, 0);
        cyc(1, 32'h400, 32'h900, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 32'h304 + 32'(i * 4));
        cyc(0, 0, 0, 1, 0, 32'h0);

        // 4: mispredict on head with a same-cycle push: squashed, push dropped
        for (int i = 0; i < 3; i++) cyc(1, 32'h500 + 32'(i * 4), 32'h800, 0, 0, 0);
        cyc(1, 32'h600, 32'h700, 1, 1, 32'hdead0000);
        cyc(0, 0, 0, 1, 0, 32'h604);

        // 5: saturate pc=0x40 taken, then one not-taken keeps taken, another flips it
        for (int i = 0; i < 5; i++) begin
            cyc(1, 32'h40, 32'h80, 0, 0, 0);
            cyc(0, 0, 0, 1, 1, 32'h80);
        end
        cyc(1, 32'h40, 32'h80, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 32'h44);
        cyc(1, 32'h40, 32'h80, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 32'h44);
        cyc(0, 32'h40, 0, 0, 0, 0);

        // pc+4 wraps at the top of the address space
        cyc(1, 32'hfffffffc, 32'h10, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 32'h0);

        // 6: underflow leaves the table alone
        cyc(0, 0, 0, 1, 1, 32'h44);
        cyc(0, 32'h40, 0, 0, 0, 0);

        // Random traffic with a small PC pool so entries alias and collide
        for (int n = 0; n < 600; n++) begin
            logic pv, rv, rt;
            logic [31:0] tgt;
            pv  = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 9) < 4);
            rt  = 1'($urandom_range(0, 1));
            pc  = ($urandom_range(0, 15) == 0) ? 32'hfffffffc : 32'h1000 + 32'($urandom_range(0, 7) << 2);
            tgt = 32'h2000 + 32'($urandom_range(0, 63) << 2);
            if (m_q.size() != 0 && $urandom_range(0, 3) != 0) nx = m_q[0].nxt;
            else nx = 32'h3000 + 32'($urandom_range(0, 63) << 2);
            cyc(pv, pc, tgt, rv, rt, nx);
        end

        // Reset mid-stream: full queue and stale redirect clear with no clock edge
        cyc(1, 32'h1000, 32'h2000, 1, 0, 32'hbad00000);
        for (int i = 0; i < 4; i++) cyc(1, 32'h1100 + 32'(i * 4), 32'h2000, 0, 0, 0);
        chk("full_ready", 32'(pred_ready_o), 32'd0);
        rst_i = 1'b1;
        m_reset();
        #1;
        chk("arst_ready", 32'(pred_ready_o), 32'd1);
        chk("arst_mis", 32'(mispredict_o), 32'd0);
        chk("arst_rpc", redirect_pc_o, 32'd0);
        chk("arst_uf", 32'(underflow_o), 32'd0);
        #2;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        cyc(0, 32'h1000, 0, 1, 0, 32'h1004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
